// File: rtl/clk_div_ctrl.sv
// Programmable clock-enable controller: divisor config via valid/ready, start/stop FSM,
// one-cycle tick enable, square-wave clk_out, continuous or N-tick burst operation.
module clk_div_ctrl #(
    parameter int unsigned CNT_W   = 25,
    parameter int unsigned DEF_DIV = 16666667,
    parameter int unsigned BURST_W = 8
) (
    input  logic               clk_100MHz,
    input  logic               rst,
    input  logic [CNT_W-1:0]   cfg_div,
    input  logic               cfg_oneshot,
    input  logic [BURST_W-1:0] cfg_count,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic               start,
    input  logic               stop,
    output logic               tick,
    output logic               clk_out,
    output logic               busy,
    output logic               done
);

    localparam int unsigned BL_W = BURST_W + 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e             r_state;
    state_e             w_state_next;

    logic [CNT_W-1:0]   r_div;
    logic               r_oneshot;
    logic [BURST_W-1:0] r_count;
    logic [CNT_W-1:0]   r_cnt;
    logic [BL_W-1:0]    r_burst_left;
    logic               r_tick;
    logic               r_clk_out;
    logic               r_done;
    logic               r_busy;
    logic               r_cfg_ready;

    logic               w_xfer;
    logic [CNT_W-1:0]   w_div_sat;
    logic [BURST_W-1:0] w_count_sel;
    logic [BL_W-1:0]    w_burst_load;
    logic               w_wrap;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [BL_W-1:0]    w_burst_next;
    logic               w_tick_next;
    logic               w_clk_out_next;
    logic               w_done_next;

    // cfg_ready mirrors state == StIdle, so a transfer can only land while idle
    assign w_xfer    = cfg_valid && r_cfg_ready;
    assign w_div_sat = (cfg_div < CNT_W'(2)) ? CNT_W'(2) : cfg_div;

    // A config landing on the start edge must govern the burst length of this run
    assign w_count_sel  = w_xfer ? cfg_count : r_count;
    assign w_burst_load = (w_count_sel == '0) ? {1'b1, {BURST_W{1'b0}}} : {1'b0, w_count_sel};

    assign w_wrap = (r_cnt == (r_div - CNT_W'(1)));

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_burst_next   = r_burst_left;
        w_tick_next    = 1'b0;
        w_clk_out_next = r_clk_out;
        w_done_next    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_next = StRun;
                    w_cnt_next   = '0;
                    w_burst_next = w_burst_load;
                end
            end
            StRun: begin
                if (stop) begin
                    // Abort wins over a coincident wrap: no tick on this edge
                    w_state_next   = StIdle;
                    w_cnt_next     = '0;
                    w_clk_out_next = 1'b0;
                end else if (w_wrap) begin
                    w_cnt_next     = '0;
                    w_tick_next    = 1'b1;
                    w_clk_out_next = ~r_clk_out;
                    if (r_oneshot) begin
                        w_burst_next = r_burst_left - BL_W'(1);
                        if (r_burst_left == BL_W'(1)) begin
                            w_state_next = StDone;
                        end
                    end
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            StDone: begin
                w_state_next   = StIdle;
                w_done_next    = 1'b1;
                w_clk_out_next = 1'b0;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_burst_left <= '0;
            r_tick       <= 1'b0;
            r_clk_out    <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_cfg_ready  <= 1'b1;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_burst_left <= w_burst_next;
            r_tick       <= w_tick_next;
            r_clk_out    <= w_clk_out_next;
            r_done       <= w_done_next;
            r_cfg_ready  <= (w_state_next == StIdle);
            // Held through the done pulse so busy drops only after done
            r_busy       <= (w_state_next != StIdle) || (r_state == StDone);
        end
    end

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            r_div     <= CNT_W'(DEF_DIV);
            r_oneshot <= 1'b0;
            r_count   <= '0;
        end else if (w_xfer) begin
            r_div     <= w_div_sat;
            r_oneshot <= cfg_oneshot;
            r_count   <= cfg_count;
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign tick      = r_tick;
    assign clk_out   = r_clk_out;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl: continuous, one-shot, divisor clamp,
// stop priority, stalled configuration and asynchronous reset mid-burst.
module tb_clk_div_ctrl;

    localparam int unsigned CNT_W   = 25;
    localparam int unsigned DEF_DIV = 16666667;
    localparam int unsigned BURST_W = 8;

    logic               clk_100MHz;
    logic               rst;
    logic [CNT_W-1:0]   cfg_div;
    logic               cfg_oneshot;
    logic [BURST_W-1:0] cfg_count;
    logic               cfg_valid;
    logic               cfg_ready;
    logic               start;
    logic               stop;
    logic               tick;
    logic               clk_out;
    logic               busy;
    logic               done;

    int n_tests;
    int n_fail;

    clk_div_ctrl #(
        .CNT_W  (CNT_W),
        .DEF_DIV(DEF_DIV),
        .BURST_W(BURST_W)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .rst        (rst),
        .cfg_div    (cfg_div),
        .cfg_oneshot(cfg_oneshot),
        .cfg_count  (cfg_count),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .start      (start),
        .stop       (stop),
        .tick       (tick),
        .clk_out    (clk_out),
        .busy       (busy),
        .done       (done)
    );

    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic do_cfg(input int div, input bit oneshot, input int count);
        cfg_div     = CNT_W'(div);
        cfg_oneshot = oneshot;
        cfg_count   = BURST_W'(count);
        cfg_valid   = 1'b1;
        step();
        cfg_valid   = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    // Called just after the start edge; k counts edges since the start edge
    task automatic run_window(input string tag, input int div, input int n);
        for (int k = 0; k <= n; k++) begin
            if (k > 0) step();
            check($sformatf("%s tick k=%0d", tag, k), 32'(tick), 32'(k > 0 && k % div == 0));
            check($sformatf("%s clk_out k=%0d", tag, k), 32'(clk_out), 32'((k / div) % 2));
            check($sformatf("%s busy k=%0d", tag, k), 32'(busy), 32'd1);
            check($sformatf("%s ready k=%0d", tag, k), 32'(cfg_ready), 32'd0);
        end
    endtask

    initial begin
        int ticks;
        int done_k;
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b1;
        cfg_div     = '0;
        cfg_oneshot = 1'b0;
        cfg_count   = '0;
        cfg_valid   = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        #23;
        check("rst tick", 32'(tick), 32'd0);
        check("rst clk_out", 32'(clk_out), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst ready", 32'(cfg_ready), 32'd1);
        check("rst div", 32'(dut.r_div), 32'(DEF_DIV));
        step();
        rst = 1'b0;
        step();

        // Continuous, divisor 4
        do_cfg(4, 1'b0, 0);
        do_start();
        run_window("cont4", 4, 16);
        do_stop();
        check("cont4 stop busy", 32'(busy), 32'd0);
        check("cont4 stop clk_out", 32'(clk_out), 32'd0);

        // One-shot, divisor 3, three ticks
        do_cfg(3, 1'b1, 3);
        do_start();
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) step();
            check($sformatf("os3 tick k=%0d", k), 32'(tick), 32'(k == 3 || k == 6 || k == 9));
            check($sformatf("os3 clk_out k=%0d", k), 32'(clk_out),
                  32'((k >= 3 && k <= 5) || k == 9));
            check($sformatf("os3 done k=%0d", k), 32'(done), 32'(k == 10));
            check($sformatf("os3 busy k=%0d", k), 32'(busy), 32'(k <= 10));
            check($sformatf("os3 ready k=%0d", k), 32'(cfg_ready), 32'(k >= 10));
        end

        // Divisors below 2 clamp to 2
        do_cfg(0, 1'b0, 0);
        do_start();
        run_window("div0", 2, 8);
        do_stop();
        do_cfg(1, 1'b0, 0);
        do_start();
        run_window("div1", 2, 8);
        do_stop();

        // Stop on the wrap cycle beats the tick
        do_cfg(5, 1'b0, 0);
        do_start();
        run_window("div5", 5, 4);
        do_stop();
        check("stopwrap tick", 32'(tick), 32'd0);
        check("stopwrap busy", 32'(busy), 32'd0);
        check("stopwrap clk_out", 32'(clk_out), 32'd0);
        check("stopwrap done", 32'(done), 32'd0);
        check("stopwrap ready", 32'(cfg_ready), 32'd1);
        step();
        check("stopwrap tick+1", 32'(tick), 32'd0);
        check("stopwrap done+1", 32'(done), 32'd0);

        // Config held through RUN is stalled, then taken once idle
        do_cfg(4, 1'b0, 0);
        do_start();
        cfg_div   = CNT_W'(7);
        cfg_valid = 1'b1;
        run_window("stall", 4, 8);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stall idle ready", 32'(cfg_ready), 32'd1);
        step();
        cfg_valid = 1'b0;
        check("stall xfer ready", 32'(cfg_ready), 32'd1);
        do_start();
        run_window("div7", 7, 14);
        do_stop();

        // One-shot with count 0 gives 256 ticks
        do_cfg(2, 1'b1, 0);
        do_start();
        ticks  = 0;
        done_k = -1;
        for (int k = 1; k <= 600; k++) begin
            step();
            if (tick) ticks++;
            if (done) begin
                done_k = k;
                break;
            end
        end
        check("burst256 ticks", 32'(ticks), 32'd256);
        check("burst256 done_k", 32'(done_k), 32'd513);

        // Asynchronous reset in the middle of a burst
        do_start();
        for (int k = 1; k <= 22; k++) step();
        check("prerst clk_out", 32'(clk_out), 32'd1);
        check("prerst busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst tick", 32'(tick), 32'd0);
        check("midrst clk_out", 32'(clk_out), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst ready", 32'(cfg_ready), 32'd1);
        check("midrst div", 32'(dut.r_div), 32'(DEF_DIV));
        step();
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("postrst ready k=%0d", k), 32'(cfg_ready), 32'd1);
            check($sformatf("postrst tick k=%0d", k), 32'(tick), 32'd0);
            check($sformatf("postrst busy k=%0d", k), 32'(busy), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
